// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default baud divisor, parity helper.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 4;

  // Common state names for both transmit and receive FSMs
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5,
    MARK   = 3'd6
  } uart_state_e;

  // Parity over up to 8 data bits; narrower words are zero-extended by the caller
  function automatic logic parity_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte/break handshake between the byte producer and the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 valid;
  logic                 send_break;
  logic                 ready;

  modport master (output data_in, output valid, output send_break, input ready);
  modport slave  (input data_in, input valid, input send_break, output ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Modulo-CLKS_PER_BIT counter; tick_c marks the last cycle of each bit time.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Count 0..CLKS_PER_BIT-1, wrap on tick, hold at zero while cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises bytes LSB first with optional parity, 1/2 stop bits, and BREAK.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned BREAK_BITS   = 12
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      busy
);

  localparam int unsigned MAX_BITS_A = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int unsigned MAX_BITS   = (BREAK_BITS > MAX_BITS_A) ? BREAK_BITS : MAX_BITS_A;
  localparam int unsigned BIT_W      = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_d;
  logic                 tick_c;
  logic                 timer_clr_c;

  assign bus.ready   = ready_q;
  assign timer_clr_c = (state_q == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clr_c),
    .tick_c (tick_c)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      ready_q <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx      <= tx_d;
      ready_q <= ready_d;
      busy    <= busy_d;
    end
  end

  // Next state and next output values; tx_d is the line level of the next state
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    tx_d    = tx;
    ready_d = ready_q;
    busy_d  = busy;

    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (bus.send_break) begin
          state_d = BREAK;
          bit_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end else if (bus.valid) begin
          state_d = START;
          shift_d = bus.data_in;
          par_d   = parity_calc(8'(bus.data_in), 1'(PARITY_ODD));
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (tick_c) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick_c) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tick_c) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick_c) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            state_d = IDLE;
            bit_d   = '0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
          tx_d = 1'b1;
        end
      end
      BREAK: begin
        if (tick_c) begin
          if (bit_q == BIT_W'(BREAK_BITS - 1)) begin
            state_d = MARK;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      MARK: begin
        if (tick_c) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1, 8E1 and 8O1 instances driven by the same stimulus.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid;
  logic       send_break;

  logic tx_a, busy_a, tx_pe, busy_pe, tx_po, busy_po;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(8)) bus_a  ();
  uart_tx_if #(.DATA_BITS(8)) bus_pe ();
  uart_tx_if #(.DATA_BITS(8)) bus_po ();

  assign bus_a.data_in     = data_in;
  assign bus_a.valid       = valid;
  assign bus_a.send_break  = send_break;
  assign bus_pe.data_in    = data_in;
  assign bus_pe.valid      = valid;
  assign bus_pe.send_break = send_break;
  assign bus_po.data_in    = data_in;
  assign bus_po.valid      = valid;
  assign bus_po.send_break = send_break;

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
            .STOP_BITS(1), .BREAK_BITS(12))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a), .tx(tx_a), .busy(busy_a));

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
            .STOP_BITS(1), .BREAK_BITS(12))
    dut_pe (.clk(clk), .reset(reset), .bus(bus_pe), .tx(tx_pe), .busy(busy_pe));

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
            .STOP_BITS(1), .BREAK_BITS(12))
    dut_po (.clk(clk), .reset(reset), .bus(bus_po), .tx(tx_po), .busy(busy_po));

  // Single comparison point: count and report
  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_idle_all(input string tag);
    chk({tag, " a_tx"},    tx_a,         1'b1);
    chk({tag, " a_rdy"},   bus_a.ready,  1'b1);
    chk({tag, " a_busy"},  busy_a,       1'b0);
    chk({tag, " pe_tx"},   tx_pe,        1'b1);
    chk({tag, " pe_rdy"},  bus_pe.ready, 1'b1);
    chk({tag, " po_tx"},   tx_po,        1'b1);
    chk({tag, " po_rdy"},  bus_po.ready, 1'b1);
  endtask

  // Frames are written MSB..LSB = stop, [parity], data[7:0], start
  task automatic run_frame(input logic [7:0] b, input logic [9:0] fa,
                           input logic [10:0] fpe, input logic [10:0] fpo);
    @(negedge clk);
    data_in = b;
    valid   = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      if (c == 0) valid = 1'b0;
      chk($sformatf("a_tx %h c%0d", b, c), tx_a, (c < 40) ? fa[4'(c / 4)] : 1'b1);
      chk($sformatf("a_rdy %h c%0d", b, c), bus_a.ready, 1'(c >= 40));
      chk($sformatf("a_busy %h c%0d", b, c), busy_a, 1'(c < 40));
      chk($sformatf("pe_tx %h c%0d", b, c), tx_pe, (c < 44) ? fpe[4'(c / 4)] : 1'b1);
      chk($sformatf("pe_rdy %h c%0d", b, c), bus_pe.ready, 1'(c >= 44));
      chk($sformatf("po_tx %h c%0d", b, c), tx_po, (c < 44) ? fpo[4'(c / 4)] : 1'b1);
      chk($sformatf("po_rdy %h c%0d", b, c), bus_po.ready, 1'(c >= 44));
    end
  endtask

  // Two frames with valid held: second start bit exactly 41 cycles after the first
  task automatic run_back_to_back();
    logic [9:0] f0;
    logic [9:0] f1;
    logic       exp_tx;
    f0 = 10'b1_0000_0000_0;
    f1 = 10'b1_1111_1111_0;
    @(negedge clk);
    data_in = 8'h00;
    valid   = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 86; c++) begin
      @(negedge clk);
      if (c == 0) data_in = 8'hFF;
      if (c < 40)       exp_tx = f0[4'(c / 4)];
      else if (c == 40) exp_tx = 1'b1;
      else if (c < 81)  exp_tx = f1[4'((c - 41) / 4)];
      else              exp_tx = 1'b1;
      chk($sformatf("b2b_tx c%0d", c), tx_a, exp_tx);
      chk($sformatf("b2b_rdy c%0d", c), bus_a.ready, 1'(c == 40 || c >= 81));
      if (c == 41) valid = 1'b0;
    end
  endtask

  // valid and send_break together: BREAK wins, byte is dropped
  task automatic run_break();
    @(negedge clk);
    data_in    = 8'h55;
    valid      = 1'b1;
    send_break = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c == 0) begin
        valid      = 1'b0;
        send_break = 1'b0;
      end
      chk($sformatf("brk_a_tx c%0d", c), tx_a, 1'(c >= 48));
      chk($sformatf("brk_a_rdy c%0d", c), bus_a.ready, 1'(c >= 52));
      chk($sformatf("brk_a_busy c%0d", c), busy_a, 1'(c < 52));
      chk($sformatf("brk_pe_tx c%0d", c), tx_pe, 1'(c >= 48));
      chk($sformatf("brk_po_rdy c%0d", c), bus_po.ready, 1'(c >= 52));
    end
  endtask

  // Abort a frame with reset at cycle 15 and confirm nothing resumes
  task automatic run_reset_mid_frame();
    logic [9:0] fa;
    fa = 10'b1_1010_0101_0;
    @(negedge clk);
    data_in = 8'hA5;
    valid   = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      if (c == 0) valid = 1'b0;
      chk($sformatf("rst_a_tx c%0d", c), tx_a, fa[4'(c / 4)]);
      chk($sformatf("rst_a_rdy c%0d", c), bus_a.ready, 1'b0);
    end
    reset = 1'b1;
    #1;
    chk_idle_all("rst_async");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk_idle_all($sformatf("rst_post c%0d", c));
    end
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = 8'h00;
    valid      = 1'b0;
    send_break = 1'b0;
    #1;
    chk_idle_all("in_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk_idle_all($sformatf("idle c%0d", c));
    end

    // 0xA5: four ones -> even parity 0, odd parity 1
    run_frame(8'hA5, 10'b1_1010_0101_0, 11'b1_0_1010_0101_0, 11'b1_1_1010_0101_0);
    // 0x07: three ones -> even parity 1, odd parity 0
    run_frame(8'h07, 10'b1_0000_0111_0, 11'b1_1_0000_0111_0, 11'b1_0_0000_0111_0);

    run_back_to_back();
    repeat (10) @(negedge clk);
    chk_idle_all("after_b2b");

    run_break();
    chk_idle_all("after_break");

    run_reset_mid_frame();
    // 0x3C: four ones -> even parity 0, odd parity 1
    run_frame(8'h3C, 10'b1_0011_1100_0, 11'b1_0_0011_1100_0, 11'b1_1_0011_1100_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
